// File: rtl/sum_display_pkg.sv
// sum_display_pkg: shared types and constants for the sum display stage.
// Holds the capture/convert FSM encoding, special segment patterns,
// double-dabble iteration count and the anode patterns for the two live digits.
package sum_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One shift per input bit of the 5-bit sum
  localparam int DD_ITERS = 5;
  localparam int ITER_W   = 3;

  // Active-low anodes; an[3:2] are unused and held off
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment pattern.
// Ports: digit (4-bit BCD), blank (all segments off), dash (g only, wins over
// blank), seg (active-low {g,f,e,d,c,b,a}). Non-BCD digits decode to blank.
module seg7_decode
  import sum_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  end

  always_comb begin
    seg = glyph;
    if (dash)
      seg = SEG_DASH;
    else if (blank)
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/sum_display.sv
// sum_display: captures the adder result on a rising edge of done, converts it
// to BCD with a sequential double-dabble and scans it onto a 4-digit display.
// Ports: clk, reset (async, active-high), sum[4:0], done (async) in;
// seg[6:0], an[3:0] (both active-low, registered) and valid out.
module sum_display
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sum,
  input  logic       done,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       valid
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------
  // done synchronizer and rising-edge detect
  // ---------------------------------------------------------------
  logic s1, s2, d_q;
  logic rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      d_q <= 1'b0;
    end else begin
      s1  <= done;
      s2  <= s1;
      d_q <= s2;
    end
  end

  assign rise = s2 & ~d_q;

  // ---------------------------------------------------------------
  // Capture / convert FSM
  // ---------------------------------------------------------------
  state_t state, state_nxt;
  logic [ITER_W-1:0] iter;
  logic start, step, load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = CONVERT;
      // The final iteration runs on the same edge that moves to LOAD
      CONVERT: if (iter == ITER_W'(DD_ITERS - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    step  = 1'b0;
    load  = 1'b0;
    case (state)
      IDLE:    start = rise;
      CONVERT: step  = 1'b1;
      LOAD:    load  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Double-dabble datapath
  // ---------------------------------------------------------------
  logic [4:0] shift_q;
  logic [7:0] bcd_q;
  logic [7:0] bcd_adj;

  // Nibbles >= 5 get +3 so the following shift carries correctly into the
  // next decade. Input max is 31, so the tens nibble never exceeds 3.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      iter    <= '0;
    end else if (start) begin
      shift_q <= sum;
      bcd_q   <= '0;
      iter    <= '0;
    end else if (step) begin
      {bcd_q, shift_q} <= {bcd_adj[6:0], shift_q, 1'b0};
      iter             <= iter + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Display registers
  // ---------------------------------------------------------------
  logic [7:0] disp_q, disp_nxt;
  logic       valid_nxt;

  assign disp_nxt  = load ? bcd_q : disp_q;
  assign valid_nxt = load | valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      valid  <= 1'b0;
    end else begin
      disp_q <= disp_nxt;
      valid  <= valid_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Refresh counter and digit select
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             sel, sel_nxt, wrap;

  assign wrap    = (cnt == CNT_LAST);
  assign sel_nxt = sel ^ wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sel <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      sel <= sel_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Output registers. Decoding from the next-cycle select and display
  // values lets seg and an switch on the same edge (no ghosting) and lets a
  // freshly loaded result appear on the LOAD edge itself.
  // ---------------------------------------------------------------
  logic [3:0] dec_digit;
  logic       dec_blank, dec_dash;
  logic [6:0] dec_seg;

  assign dec_digit = sel_nxt ? disp_nxt[7:4] : disp_nxt[3:0];
  assign dec_blank = sel_nxt & (disp_nxt[7:4] == 4'd0);
  assign dec_dash  = ~valid_nxt;

  seg7_decode u_dec (
    .digit (dec_digit),
    .blank (dec_blank),
    .dash  (dec_dash),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_DASH;
      an  <= AN_ONES;
    end else begin
      seg <= dec_seg;
      an  <= sel_nxt ? AN_TENS : AN_ONES;
    end
  end

endmodule

// File: tb/tb_sum_display.sv
module tb_sum_display;
  import sum_display_pkg::*;

  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sum;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;
  logic       valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sum_display #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sum   (sum),
    .done  (done),
    .seg   (seg),
    .an    (an),
    .valid (valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the requested slot, then compare its segments.
  task automatic check_slot(input string tag, input logic [3:0] target, input logic [6:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    if (found) chk(tag, 32'(seg), 32'(exp));
    else       chk({tag, "_an_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise done just after a negedge: the next posedge is edge 1.
  // Returns sampled just after edge 9.
  task automatic capture(input string tag, input logic [4:0] v, input bit check_latency);
    sum  = v;
    done = 1'b1;
    repeat (8) @(negedge clk);
    if (check_latency) chk({tag, "_valid_e8"}, 32'(valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_e9"}, 32'(valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    done  = 1'b0;
    sum   = 5'd0;
    #1;
    chk("rst_seg",   32'(seg),   32'(DASH));
    chk("rst_an",    32'(an),    32'(AN_ONES));
    chk("rst_valid", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle scan: dashes, anodes alternate every 4 cycles, no valid.
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      chk("idle_an", 32'(an), ((n / 4) % 2) ? 32'(AN_TENS) : 32'(AN_ONES));
      chk("idle_seg", 32'(seg), 32'(DASH));
      chk("idle_valid", 32'(valid), 32'd0);
    end

    // 15: latency and first-visible value on edge 9
    capture("c15", 5'd15, 1'b1);
    chk("c15_e9_seg", 32'(seg), (an === AN_ONES) ? 32'(S5) : 32'(S1));
    check_slot("c15_ones", AN_ONES, S5);
    check_slot("c15_tens", AN_TENS, S1);

    // done falls, sum changes: display holds 15
    done = 1'b0;
    sum  = 5'd7;
    repeat (20) @(negedge clk);
    chk("hold_valid", 32'(valid), 32'd1);
    check_slot("hold_ones", AN_ONES, S5);
    check_slot("hold_tens", AN_TENS, S1);

    // second rise captures 7
    capture("c7", 5'd7, 1'b0);
    check_slot("c7_ones", AN_ONES, S7);
    check_slot("c7_tens", AN_TENS, BLANK);

    // 30
    do_reset();
    capture("c30", 5'd30, 1'b1);
    check_slot("c30_ones", AN_ONES, S0);
    check_slot("c30_tens", AN_TENS, S3);

    // 0: tens blanked, ones shows 0
    do_reset();
    capture("c0", 5'd0, 1'b1);
    chk("c0_valid", 32'(valid), 32'd1);
    check_slot("c0_ones", AN_ONES, S0);
    check_slot("c0_tens", AN_TENS, BLANK);

    // 28 aborted by reset mid-conversion
    do_reset();
    sum  = 5'd28;
    done = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    check_slot("abort_ones", AN_ONES, DASH);
    check_slot("abort_tens", AN_TENS, DASH);

    capture("c9", 5'd9, 1'b1);
    check_slot("c9_ones", AN_ONES, S9);
    check_slot("c9_tens", AN_TENS, BLANK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sum_display.md
# sum_display

Downstream display stage for the serial adder on the Spartan-7 board. It watches the adder's 5-bit `sum` and `done` outputs and captures the result on the rising edge of `done`. It converts the result (0..30) to two BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed, active-low 4-digit seven-segment display.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per digit slot; 1 kHz per digit at 100 MHz.
- `clk` in 1: system clock, 100 MHz board clock, the same one that feeds the adder.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `sum` in 5: adder result; stable whenever `done` is high.
- `done` in 1: adder completion flag, generated in the adder's divided-clock domain and treated as asynchronous here.
- `seg` out 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `an` out 4: anodes, active-low; an[0] ones, an[1] tens, an[3:2] unused.
- `valid` out 1: high while the display shows a captured result.

## Operation
- `done` passes through a 2-flop synchronizer (s1, s2), then a registered copy d_q; rise = s2 & ~d_q.
- FSM states:
  - IDLE: on rise, load `sum` into shift reg, clear BCD reg {tens[3:0], ones[3:0]}, set iter=0, go to CONVERT.
  - CONVERT: each cycle, add 3 to any BCD nibble ≥5, then shift {bcd, shift} left 1; iter++. After 5 iterations go to LOAD.
  - LOAD: copy BCD into display regs, set `valid`=1, return to IDLE.
- A rise seen outside IDLE is ignored; the adder asserts `done` once per reset.
- A fall of `done` without reset does not change the display.
- Display content:
  - Before the first capture (`valid`=0): both active digits show dash (g only, 7'b0111111).
  - After capture: ones digit always shown; tens digit blank (7'b1111111) when tens=0.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 5=0010010, 8=0000000; the rest are standard.
- Multiplexing:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - sel toggles on wrap. sel=0 drives an=4'b1110 with ones; sel=1 drives an=4'b1101 with tens.
  - an[3:2] are always 1.
- Reset clears the synchronizer, FSM (→IDLE), BCD, display regs, counter and sel, and sets `valid`=0. Reset mid-CONVERT abandons the conversion.

## Timing
- Reset values: `seg`=7'b0111111, `an`=4'b1110, `valid`=0.
- Capture latency, counting edge 1 as the first clk edge at which `done`=1 is sampled into s1:
  - Edge 2: s2.
  - Edge 3: rise, capture into shift reg, state CONVERT.
  - Edges 4–8: the five iterations.
  - Edge 9: LOAD; display regs and `valid` update.
  - `seg` shows the new value from edge 9 onward in the current slot.
- `seg`/`an` are registered and change together on the edge where sel toggles, so there is no ghosting between digits.
- Full scan period is 2×REFRESH_DIV cycles.
- Arithmetic: 5-bit input, 8-bit BCD. The max input 31 gives 3/1, so no overflow path is needed.

## Structure
- Package `sum_display_pkg`:
  - State enum {IDLE, CONVERT, LOAD}.
  - SEG_DASH and SEG_BLANK constants.
  - Iteration count constant 5.
- Sub-module `seg7_decode`: combinational, 4-bit digit plus blank/dash controls in, 7-bit active-low segments out.
- Top-level holds the synchronizer, FSM, double-dabble datapath, refresh counter and output registers.

## Test plan
- Reset, then `done`=0 for 1000 cycles (REFRESH_DIV=4) → `seg`=0111111 in both slots, an alternates 1110/1101 every 4 cycles, `valid`=0.
- `sum`=15, raise `done` → at edge 9 `valid`=1; ones slot seg=0010010 (5), tens slot seg=1111001 (1).
- `sum`=30 → ones slot 1000000 (0), tens slot 0110000 (3).
- `sum`=0 → ones slot 1000000, tens slot blank 1111111, `valid`=1.
- `sum`=28, assert `reset` at edge 5 (mid-CONVERT), release, keep `done` low → dashes, `valid`=0, FSM IDLE. Then `sum`=9 with `done` rise → ones 9, tens blank.
- After capture of 15, drop `done` and change `sum` to 7 without reset → display still shows 15. A second `done` rise then captures 7 (tens blank).
